// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, sequencer states and opcode-class helpers shared by the alu sequencer.
package alu_pkg;
   localparam logic [3:0] OP_OUT  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_MUL  = 4'hA;
   localparam logic [3:0] OP_DIV  = 4'hB;
   localparam logic [3:0] OP_MULU = 4'hC;
   localparam logic [3:0] OP_DIVU = 4'hD;
   localparam logic [3:0] OP_SLT  = 4'hE;
   localparam logic [3:0] OP_SLTU = 4'hF;

   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MD_RUN, S_MD_FIX, S_RESP} state_t;

   function automatic logic op_is_md(input logic [3:0] op);
      return op == OP_MUL || op == OP_DIV || op == OP_MULU || op == OP_DIVU;
   endfunction

   function automatic logic op_is_div(input logic [3:0] op);
      return op == OP_DIV || op == OP_DIVU;
   endfunction

   function automatic logic op_is_signed(input logic [3:0] op);
      return op == OP_MUL || op == OP_DIV;
   endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: unsigned shift-add multiply / restoring divide, one bit per step.
module alu_muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             start,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   logic [WIDTH-1:0] m;
   logic             div_mode;
   logic [WIDTH:0]   sum, rem, diff;
   logic             ge;

   always_comb begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
      rem  = {hi, lo[WIDTH-1]};
      diff = rem - {1'b0, m};
      ge   = rem >= {1'b0, m};
   end

   // multiply: lo holds the multiplier, product shifts in from the top;
   // divide: lo holds the dividend, quotient bits shift in from the bottom
   always_ff @(posedge clk) begin
      if (start) begin
         div_mode <= is_div;
         m        <= is_div ? b : a;
         hi       <= '0;
         lo       <= is_div ? a : b;
      end else if (step) begin
         if (div_mode) begin
            hi <= ge ? diff[WIDTH-1:0] : rem[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], ge};
         end else
            {hi, lo} <= {sum, lo[WIDTH-1:1]};
      end
   end
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: request/response sequencer in front of the alu; resolves compares locally
// and runs multiply/divide on the iterative unit with sign correction at the end.
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [3:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_data0,
   output logic [WIDTH-1:0] alu_data1,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_ovf,
   input  logic [3:0]       alu_cond,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [WIDTH-1:0] rsp_hi,
   output logic             rsp_ovf,
   output logic [3:0]       rsp_cond,
   output logic             rsp_divz,
   output logic             busy
);
   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               neg_a, neg_b;
   logic               accept, req_neg_a, req_neg_b;
   logic [WIDTH-1:0]   mag_a, mag_b, md_hi, md_lo;
   logic               is_alu, is_cmp, lt, is_div;
   logic [WIDTH-1:0]   ex_data, ex_hi, q, r;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   fx_data, fx_hi;
   logic               fx_ovf;

   assign req_ready = state == S_IDLE;
   assign busy      = state != S_IDLE;
   assign accept    = req_valid && state == S_IDLE;

   always_comb begin
      req_neg_a = op_is_signed(req_op) && req_a[WIDTH-1];
      req_neg_b = op_is_signed(req_op) && req_b[WIDTH-1];
      mag_a     = req_neg_a ? -req_a : req_a;
      mag_b     = req_neg_b ? -req_b : req_b;
      is_alu    = alu_opcode < OP_MUL;
      is_cmp    = alu_opcode == OP_SLT || alu_opcode == OP_SLTU;
      lt        = alu_opcode == OP_SLT ? $signed(alu_data0) < $signed(alu_data1) : alu_data0 < alu_data1;
      // anything else reaching EXEC is a divide by zero
      ex_data   = is_alu ? alu_out : is_cmp ? {{(WIDTH-1){1'b0}}, lt} : '1;
      ex_hi     = (is_alu || is_cmp) ? '0 : alu_data0;
      is_div    = op_is_div(alu_opcode);
      prod      = (neg_a ^ neg_b) ? -{md_hi, md_lo} : {md_hi, md_lo};
      q         = (neg_a ^ neg_b) ? -md_lo : md_lo;
      r         = neg_a ? -md_hi : md_hi;
      fx_data   = is_div ? q : prod[WIDTH-1:0];
      fx_hi     = is_div ? r : prod[2*WIDTH-1:WIDTH];
      fx_ovf    = is_div ? (alu_opcode == OP_DIV && alu_data0 == {1'b1, {(WIDTH-1){1'b0}}} && alu_data1 == '1)
                : alu_opcode == OP_MUL ? fx_hi != {WIDTH{fx_data[WIDTH-1]}} : fx_hi != '0;
   end

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .start  (accept),
      .step   (state == S_MD_RUN),
      .is_div (op_is_div(req_op)),
      .a      (mag_a),
      .b      (mag_b),
      .hi     (md_hi),
      .lo     (md_lo)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         neg_a      <= 1'b0;
         neg_b      <= 1'b0;
         alu_opcode <= '0;
         alu_data0  <= '0;
         alu_data1  <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_hi     <= '0;
         rsp_ovf    <= 1'b0;
         rsp_cond   <= '0;
         rsp_divz   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (req_valid) begin
               alu_opcode <= req_op;
               alu_data0  <= req_a;
               alu_data1  <= req_b;
               neg_a      <= req_neg_a;
               neg_b      <= req_neg_b;
               cnt        <= '0;
               state      <= (op_is_md(req_op) && !(op_is_div(req_op) && req_b == '0)) ? S_MD_RUN : S_EXEC;
            end
            S_EXEC: begin
               rsp_valid <= 1'b1;
               rsp_data  <= ex_data;
               rsp_hi    <= ex_hi;
               rsp_ovf   <= is_alu && alu_ovf;
               rsp_cond  <= is_alu ? alu_cond : '0;
               rsp_divz  <= !is_alu && !is_cmp;
               state     <= S_RESP;
            end
            S_MD_RUN: begin
               cnt <= cnt == CNT_W'(WIDTH - 1) ? '0 : cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) state <= S_MD_FIX;
            end
            S_MD_FIX: begin
               rsp_valid <= 1'b1;
               rsp_data  <= fx_data;
               rsp_hi    <= fx_hi;
               rsp_ovf   <= fx_ovf;
               rsp_cond  <= '0;
               rsp_divz  <= 1'b0;
               state     <= S_RESP;
            end
            S_RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: randomized and directed checks of the alu sequencer against an arithmetic model.
module tb_alu_seq_ctrl;
   typedef struct packed {
      logic [31:0] data;
      logic [31:0] hi;
      logic        ovf;
      logic [3:0]  cond;
      logic        divz;
   } res_t;

   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0;
   logic [3:0]  req_op = '0, alu_opcode, alu_cond, rsp_cond;
   logic [31:0] req_a = '0, req_b = '0, alu_data0, alu_data1, alu_out, rsp_data, rsp_hi;
   logic        alu_ovf, rsp_ovf, rsp_divz, busy;
   int          n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .alu_opcode(alu_opcode), .alu_data0(alu_data0),
      .alu_data1(alu_data1), .alu_out(alu_out), .alu_ovf(alu_ovf), .alu_cond(alu_cond),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_hi(rsp_hi),
      .rsp_ovf(rsp_ovf), .rsp_cond(rsp_cond), .rsp_divz(rsp_divz), .busy(busy)
   );

   // stand-in alu: add/sub with signed overflow, a scramble for other ops; cond = {zero,0,0,neg}
   function automatic logic [36:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] y;
      logic        v;
      y = op == 4'h1 ? a + b : op == 4'h2 ? a - b : (a ^ {b[15:0], b[31:16]}) + {28'd0, op};
      v = op == 4'h1 ? (a[31] == b[31] && y[31] != a[31]) : op == 4'h2 ? (a[31] != b[31] && y[31] != a[31]) : 1'b0;
      return {y, v, y == 32'd0, 2'b00, y[31]};
   endfunction

   assign {alu_out, alu_ovf, alu_cond} = alu_fn(alu_opcode, alu_data0, alu_data1);

   function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      res_t        r;
      longint      sa, sb, ua, ub, p, q, m;
      logic [36:0] al;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ua = {32'd0, a};           ub = {32'd0, b};
      al = alu_fn(op, a, b);
      r  = '0;
      case (op)
         4'hA, 4'hC: begin
            p = op == 4'hA ? sa * sb : ua * ub;
            {r.hi, r.data} = p;
            r.ovf = op == 4'hA ? r.hi != {32{r.data[31]}} : r.hi != 32'd0;
         end
         4'hB, 4'hD: if (b == 32'd0) begin
            r.data = '1; r.hi = a; r.divz = 1'b1;
         end else begin
            q = op == 4'hB ? sa / sb : ua / ub;
            m = op == 4'hB ? sa % sb : ua % ub;
            r.data = q[31:0]; r.hi = m[31:0];
            r.ovf  = op == 4'hB && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
         end
         4'hE: r.data = {31'd0, sa < sb};
         4'hF: r.data = {31'd0, ua < ub};
         default: begin r.data = al[36:5]; r.ovf = al[4]; r.cond = al[3:0]; end
      endcase
      return r;
   endfunction

   function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
      return (op >= 4'hA && op <= 4'hD && !((op == 4'hB || op == 4'hD) && b == 32'd0)) ? 33 : 1;
   endfunction

   // called at a negedge with the DUT idle; returns the response and edges from accept to rsp_valid
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output res_t r, output int lat);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 64) begin @(negedge clk); lat++; end
      r = '{rsp_data, rsp_hi, rsp_ovf, rsp_cond, rsp_divz};
   endtask

   task automatic release_rsp(input int delay);
      repeat (delay) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if ({req_ready, rsp_valid, busy} !== 3'b100 || rsp_data !== 0 || rsp_hi !== 0 || alu_opcode !== 0
          || {rsp_ovf, rsp_cond, rsp_divz} !== 6'd0) begin
         n_bad++;
         $display("FAIL reset: ready/valid/busy=%b data=%h hi=%h op=%h flags=%b, required 100 0 0 0 0",
                  {req_ready, rsp_valid, busy}, rsp_data, rsp_hi, alu_opcode, {rsp_ovf, rsp_cond, rsp_divz});
      end
   endtask

   task automatic test_directed;
      logic [3:0]  ops [8] = '{4'h1, 4'h2, 4'hA, 4'hD, 4'hB, 4'hB, 4'hB, 4'hE};
      logic [31:0] as  [8] = '{5, 3, 32'hFFFF_FFFD, 100, 32'hFFFF_FFF9, 32'h8000_0000, 32'h1234, 32'hFFFF_FFFF};
      logic [31:0] bs  [8] = '{7, 3, 7, 7, 2, 32'hFFFF_FFFF, 0, 1};
      res_t        golden [8] = '{
         '{32'd12, 32'd0, 1'b0, 4'h0, 1'b0},
         '{32'd0, 32'd0, 1'b0, 4'h8, 1'b0},
         '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 4'h0, 1'b0},
         '{32'd14, 32'd2, 1'b0, 4'h0, 1'b0},
         '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 4'h0, 1'b0},
         '{32'h8000_0000, 32'd0, 1'b1, 4'h0, 1'b0},
         '{32'hFFFF_FFFF, 32'h1234, 1'b0, 4'h0, 1'b1},
         '{32'd1, 32'd0, 1'b0, 4'h0, 1'b0}};
      int          lat_req [8] = '{1, 1, 33, 33, 33, 33, 1, 1};
      res_t        r;
      int          lat;
      for (int i = 0; i < 8; i++) begin
         issue(ops[i], as[i], bs[i], r, lat);
         n_cmp += 2;
         if (r !== golden[i]) begin
            n_bad++;
            $display("FAIL directed[%0d] op %h: got %h required %h", i, ops[i], r, golden[i]);
         end
         if (lat !== lat_req[i]) begin
            n_bad++;
            $display("FAIL directed_lat[%0d]: got %0d required %0d", i, lat, lat_req[i]);
         end
         release_rsp(0);
      end
      issue(4'hF, 32'hFFFF_FFFF, 1, r, lat);
      n_cmp++;
      if (r.data !== 32'd0) begin n_bad++; $display("FAIL sltu: got %h required 0", r.data); end
      release_rsp(0);
   endtask

   task automatic test_random;
      logic [3:0]  op;
      logic [31:0] a, b;
      res_t        r, e;
      int          lat;
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 2)) : $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
         e = model(op, a, b);
         issue(op, a, b, r, lat);
         n_cmp += 2;
         if (r !== e) begin
            n_bad++;
            $display("FAIL random op %h a %h b %h: got %h required %h", op, a, b, r, e);
         end
         if (lat !== exp_lat(op, b)) begin
            n_bad++;
            $display("FAIL random_lat op %h: got %0d required %0d", op, lat, exp_lat(op, b));
         end
         release_rsp($urandom_range(0, 3));
      end
   endtask

   task automatic test_back_to_back;
      res_t r, e, snap;
      int   lat;
      issue(4'hC, 32'h0001_2345, 32'h0000_6789, snap, lat);
      req_valid = 1'b1; req_op = 4'h1; req_a = 32'h7FFF_FFFF; req_b = 32'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         r = '{rsp_data, rsp_hi, rsp_ovf, rsp_cond, rsp_divz};
         n_cmp++;
         if (r !== snap || !rsp_valid || req_ready) begin
            n_bad++;
            $display("FAIL stall[%0d]: got %h valid %b ready %b required %h valid 1 ready 0", i, r, rsp_valid, req_ready, snap);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_cmp++;
      if (rsp_valid || !req_ready) begin
         n_bad++;
         $display("FAIL handshake: valid %b ready %b required valid 0 ready 1", rsp_valid, req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
      n_cmp++;
      if (!busy) begin n_bad++; $display("FAIL b2b_accept: busy %b required 1", busy); end
      lat = 0;
      while (!rsp_valid && lat < 64) begin @(negedge clk); lat++; end
      e = model(4'h1, 32'h7FFF_FFFF, 32'd1);
      r = '{rsp_data, rsp_hi, rsp_ovf, rsp_cond, rsp_divz};
      n_cmp++;
      if (r !== e || lat !== 1) begin
         n_bad++;
         $display("FAIL b2b_result: got %h lat %0d required %h lat 1", r, lat, e);
      end
      release_rsp(0);
   endtask

   task automatic test_reset_mid;
      res_t r;
      int   lat;
      req_valid = 1'b1; req_op = 4'hA; req_a = 32'h1234_5678; req_b = 32'h9ABC_DEF0;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (busy || rsp_valid || !req_ready) begin
         n_bad++;
         $display("FAIL reset_mid: busy %b valid %b ready %b required 0 0 1", busy, rsp_valid, req_ready);
      end
      issue(4'hC, 32'd3, 32'd4, r, lat);
      n_cmp++;
      if (r !== res_t'({32'd12, 32'd0, 6'd0}) || lat !== 33) begin
         n_bad++;
         $display("FAIL reset_mid_mulu: got %h lat %0d required data c lat 33", r, lat);
      end
      release_rsp(0);
   endtask

   initial begin
      test_reset;
      test_directed;
      test_random;
      test_back_to_back;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
